scoreboard_ctrl: RTL and testbench
==================================

Name: scoreboard_ctrl

Overview:
- Issue-side hazard controller for the 32-entry register scoreboard.
- Tracks which architectural registers have an in-flight producer and which functional unit (FU) owns each one.
- Gates instruction issue on RAW/WAW hazards and clears entries on writeback.
- Sits between decode/issue and the execute FUs, and supports pipeline flush and drain-to-idle for exceptions and syscalls.

Parameters:
- NUM_FU, 4, number of functional units that can own a pending write.
- FU_W, $clog2(NUM_FU), width of the FU tag.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- issue_valid  in  1  decode offers an instruction
- issue_ready  out  1  controller accepts; fire = issue_valid & issue_ready
- issue_src0  in  5  source register 0
- issue_src1  in  5  source register 1
- issue_dst  in  5  destination register
- issue_dst_wen  in  1  instruction writes issue_dst
- issue_fu  in  FU_W  FU that will produce issue_dst
- wb0_valid, wb1_valid  in  1  writeback port strobes
- wb0_addr, wb1_addr  in  5  writeback register
- wb0_fu, wb1_fu  in  FU_W  writeback producer tag
- flush  in  1  squash all in-flight producers
- drain_req  in  1  request stop-issue until all writes retire
- drain_done  out  1  one-cycle pulse when drained
- busy_vec  out  32  per-register pending bit
- stall_cnt  out  32  cycles with issue_valid=1 and issue_ready=0

Behaviour:
- Per-register state: busy bit plus FU tag (owner).
- Register 0 is never marked busy; issue_dst=0 is ignored.
- Reset: busy_vec=0, all owner tags=0, state=RUN, issue_ready=0 during the reset cycle, drain_done=0, stall_cnt=0.
- Hazards:
  - RAW: busy[issue_src0] or busy[issue_src1].
  - WAW: issue_dst_wen & busy[issue_dst].
  - issue_ready = state==RUN & !flush & !RAW & !WAW.
  - Source 0 reads as never busy.
- Issue fire with issue_dst_wen & dst!=0: busy[dst]<=1 and owner[dst]<=issue_fu at the next edge. Visible to the following cycle's hazard check; no bypass in the base build.
- Writeback: on wbN_valid, clear busy[wbN_addr] only if owner[wbN_addr]==wbN_fu. A tag mismatch (stale result) is ignored.
- Both WB ports on the same register: clear if either tag matches.
- Simultaneous issue-set and WB-clear on the same register: issue wins (busy=1, new owner).
- Flush: at the next edge busy_vec<=0. The issue arriving in the flush cycle is rejected (ready=0). WB in the flush cycle is ignored. Flush has priority over every other update.
- State machine, states RUN and DRAIN:
  - RUN -> DRAIN when drain_req=1. issue_ready=0 from that same cycle.
  - DRAIN -> RUN when the next-state busy_vec==0 (including WB/flush of the current cycle). drain_done pulses 1 in that cycle.
  - drain_req with busy_vec already 0: drain_done pulses in the same cycle and the state stays RUN.
  - Flush while in DRAIN empties the scoreboard and completes the drain in that cycle.
- stall_cnt: increments when issue_valid & !issue_ready, saturates at 2^32-1, and is cleared only by rst.
- Reset mid-operation: all pending state is discarded; no drain_done is emitted.

Optional Feature:
- Macro: SB_WB_BYPASS_EN.
- Defined: a same-cycle writeback whose tag matches the current owner removes the RAW/WAW hazard on that register combinationally, so issue_ready can assert in the WB cycle.
- Undefined: hazards are computed purely from registered busy_vec, giving one extra cycle of stall after WB.
- The drain_done timing is identical in both builds.

Decomposition:
- Shared package (sb_pkg):
  - REG_ADDR (5-bit).
  - FU_TAG typedef.
  - SB_ENTRY struct {busy, owner}.
  - Enum SB_STATE {RUN, DRAIN}.
  - Constant NUM_ARCH_REGS=32.
- One natural sub-module: sb_hazard_check. Purely combinational: src/dst plus entry lookups plus optional bypass -> raw, waw.
- The entry array, FSM and counter live in the top.

Test Plan:
- Reset, then issue dst=$5 fu=1 -> next cycle busy_vec[5]=1. Issue src0=$5 -> ready=0 and stall_cnt increments. WB0 addr=5 fu=1 -> busy clears and issue proceeds the cycle after (same cycle with SB_WB_BYPASS_EN).
- Issue dst=$0 -> busy_vec stays 0. src0=$0 never stalls.
- Owner[$7]=2, WB addr=7 fu=3 -> busy[7] stays 1. WB fu=2 -> clears.
- Issue dst=$9 fu=0 in the same cycle as WB addr=9 fu=0 (with busy[9]=1) -> busy[9]=1, owner=0.
- busy on $3,$4 plus drain_req -> ready=0. WB $3, then WB $4 -> drain_done pulses exactly once, in the $4 WB cycle. State returns to RUN.
- busy on 6 registers, flush=1 with issue_valid=1 -> issue rejected; busy_vec=0 next cycle. Flush during DRAIN -> drain_done in the flush cycle.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared types for the register scoreboard: register/FU tags, entry layout and controller states.
// Build option SB_WB_BYPASS_EN (see sb_hazard_check) does not change anything declared here.
package sb_pkg;

  localparam int NUM_ARCH_REGS = 32;
  localparam int SB_NUM_FU     = 4;
  localparam int SB_FU_W       = $clog2(SB_NUM_FU);

  typedef logic [4:0]         REG_ADDR;
  typedef logic [SB_FU_W-1:0] FU_TAG;

  typedef struct packed {
    logic  busy;
    FU_TAG owner;
  } SB_ENTRY;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } SB_STATE;

endpackage

// File: rtl/sb_hazard_check.sv
// Combinational RAW/WAW detection against the scoreboard busy bits.
// With SB_WB_BYPASS_EN defined, registers cleared by a same-cycle writeback no longer count as pending.
module sb_hazard_check
  import sb_pkg::*;
(
  input  logic [NUM_ARCH_REGS-1:0] busy_i,
`ifdef SB_WB_BYPASS_EN
  input  logic [NUM_ARCH_REGS-1:0] wbClr_i,
`endif
  input  REG_ADDR                  src0_i,
  input  REG_ADDR                  src1_i,
  input  REG_ADDR                  dst_i,
  input  logic                     dstWen_i,
  output logic                     raw_o,
  output logic                     waw_o
);

  logic [NUM_ARCH_REGS-1:0] pending;

`ifdef SB_WB_BYPASS_EN
  assign pending = busy_i & ~wbClr_i;
`else
  assign pending = busy_i;
`endif

  // Register 0 is hard-wired and never has a producer to wait on.
  assign raw_o = ((src0_i != '0) && pending[src0_i]) ||
                 ((src1_i != '0) && pending[src1_i]);
  assign waw_o = dstWen_i && (dst_i != '0) && pending[dst_i];

endmodule

// File: rtl/scoreboard_ctrl.sv
// Issue-side register scoreboard: tracks pending producers per register, gates issue on RAW/WAW,
// clears on tag-matched writeback, and supports flush and drain-to-idle. Option: SB_WB_BYPASS_EN.
module scoreboard_ctrl
  import sb_pkg::*;
#(
  parameter int NUM_FU = SB_NUM_FU,
  parameter int FU_W   = $clog2(NUM_FU)
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [4:0]      issue_src0,
  input  logic [4:0]      issue_src1,
  input  logic [4:0]      issue_dst,
  input  logic            issue_dst_wen,
  input  logic [FU_W-1:0] issue_fu,
  input  logic            wb0_valid,
  input  logic [4:0]      wb0_addr,
  input  logic [FU_W-1:0] wb0_fu,
  input  logic            wb1_valid,
  input  logic [4:0]      wb1_addr,
  input  logic [FU_W-1:0] wb1_fu,
  input  logic            flush,
  input  logic            drain_req,
  output logic            drain_done,
  output logic [31:0]     busy_vec,
  output logic [31:0]     stall_cnt
);

  SB_ENTRY                  entry_q [NUM_ARCH_REGS];
  SB_ENTRY                  entry_d [NUM_ARCH_REGS];
  SB_STATE                  state_q;
  logic [31:0]              stallCnt_q;
  logic [NUM_ARCH_REGS-1:0] wbClr;
  logic [NUM_ARCH_REGS-1:0] busyD;
  logic                     raw;
  logic                     waw;
  logic                     fire;
  logic                     nextEmpty;
  logic                     drainActive;

  always_comb begin
    for (int r = 0; r < NUM_ARCH_REGS; r++) begin
      busy_vec[r] = entry_q[r].busy;
    end
  end

  // A writeback only retires a register if it comes from the FU that currently owns it.
  always_comb begin
    wbClr = '0;
    for (int r = 0; r < NUM_ARCH_REGS; r++) begin
      if (wb0_valid && (wb0_addr == REG_ADDR'(r)) && (entry_q[r].owner == FU_TAG'(wb0_fu))) begin
        wbClr[r] = 1'b1;
      end
      if (wb1_valid && (wb1_addr == REG_ADDR'(r)) && (entry_q[r].owner == FU_TAG'(wb1_fu))) begin
        wbClr[r] = 1'b1;
      end
    end
  end

  sb_hazard_check uHazard (
    .busy_i   (busy_vec),
`ifdef SB_WB_BYPASS_EN
    .wbClr_i  (wbClr),
`endif
    .src0_i   (issue_src0),
    .src1_i   (issue_src1),
    .dst_i    (issue_dst),
    .dstWen_i (issue_dst_wen),
    .raw_o    (raw),
    .waw_o    (waw)
  );

  assign issue_ready = !rst && (state_q == RUN) && !drain_req && !flush && !raw && !waw;
  assign fire        = issue_valid && issue_ready;

  // Flush beats everything; otherwise a new issue overrides a same-cycle writeback clear.
  always_comb begin
    for (int r = 0; r < NUM_ARCH_REGS; r++) begin
      entry_d[r] = entry_q[r];
      if (flush) begin
        entry_d[r].busy = 1'b0;
      end else begin
        if (wbClr[r]) begin
          entry_d[r].busy = 1'b0;
        end
        if (fire && issue_dst_wen && (issue_dst == REG_ADDR'(r)) && (r != 0)) begin
          entry_d[r].busy  = 1'b1;
          entry_d[r].owner = FU_TAG'(issue_fu);
        end
      end
      busyD[r] = entry_d[r].busy;
    end
  end

  assign nextEmpty   = (busyD == '0);
  assign drainActive = (state_q == DRAIN) || drain_req;
  assign drain_done  = !rst && drainActive && nextEmpty;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_ARCH_REGS; r++) begin
        entry_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_ARCH_REGS; r++) begin
        entry_q[r] <= entry_d[r];
      end
    end
  end

  // An already-empty scoreboard completes the drain without ever leaving RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     if (drain_req && !nextEmpty) state_q <= DRAIN;
        DRAIN:   if (nextEmpty) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt_q <= '0;
    end else if (issue_valid && !issue_ready && (stallCnt_q != '1)) begin
      stallCnt_q <= stallCnt_q + 32'd1;
    end
  end

  assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Directed bench for scoreboard_ctrl: a per-cycle reference model of the scoreboard rules plus
// literal expectations on the directed scenarios. Honours SB_WB_BYPASS_EN like the design.
module tb_scoreboard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_src0;
  logic [4:0]  issue_src1;
  logic [4:0]  issue_dst;
  logic        issue_dst_wen;
  logic [1:0]  issue_fu;
  logic        wb0_valid;
  logic [4:0]  wb0_addr;
  logic [1:0]  wb0_fu;
  logic        wb1_valid;
  logic [4:0]  wb1_addr;
  logic [1:0]  wb1_fu;
  logic        flush;
  logic        drain_req;
  logic        drain_done;
  logic [31:0] busy_vec;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  scoreboard_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_src0    (issue_src0),
    .issue_src1    (issue_src1),
    .issue_dst     (issue_dst),
    .issue_dst_wen (issue_dst_wen),
    .issue_fu      (issue_fu),
    .wb0_valid     (wb0_valid),
    .wb0_addr      (wb0_addr),
    .wb0_fu        (wb0_fu),
    .wb1_valid     (wb1_valid),
    .wb1_addr      (wb1_addr),
    .wb1_fu        (wb1_fu),
    .flush         (flush),
    .drain_req     (drain_req),
    .drain_done    (drain_done),
    .busy_vec      (busy_vec),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: what the scoreboard must hold after the most recent clock edge.
  bit          mBusy  [32];
  int          mOwner [32];
  bit          mDrain = 1'b0;
  logic [31:0] mStall = '0;
  bit          nxtBusy  [32];
  int          nxtOwner [32];
  bit          expReady;
  bit          expDone;
  bit          anyBusy;
  logic [31:0] expVec;

  initial begin
    for (int r = 0; r < 32; r++) begin
      mBusy[r]  = 1'b0;
      mOwner[r] = 0;
    end
  end

  function automatic bit wbHits(input int r, input logic v, input logic [4:0] a, input logic [1:0] f);
    return v && (int'(a) == r) && (mOwner[r] == int'(f));
  endfunction

  function automatic bit pendingNow(input int r);
    if (r == 0 || !mBusy[r]) return 1'b0;
`ifdef SB_WB_BYPASS_EN
    if (wbHits(r, wb0_valid, wb0_addr, wb0_fu) || wbHits(r, wb1_valid, wb1_addr, wb1_fu)) return 1'b0;
`endif
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    expReady = !rst && !mDrain && !drain_req && !flush &&
               !pendingNow(int'(issue_src0)) && !pendingNow(int'(issue_src1)) &&
               !(issue_dst_wen && pendingNow(int'(issue_dst)));
    for (int r = 0; r < 32; r++) begin
      nxtBusy[r]  = flush ? 1'b0 : mBusy[r];
      nxtOwner[r] = mOwner[r];
      expVec[r]   = mBusy[r];
    end
    if (!flush) begin
      if (wbHits(int'(wb0_addr), wb0_valid, wb0_addr, wb0_fu)) nxtBusy[wb0_addr] = 1'b0;
      if (wbHits(int'(wb1_addr), wb1_valid, wb1_addr, wb1_fu)) nxtBusy[wb1_addr] = 1'b0;
      if (issue_valid && expReady && issue_dst_wen && issue_dst != 5'd0) begin
        nxtBusy[issue_dst]  = 1'b1;
        nxtOwner[issue_dst] = int'(issue_fu);
      end
    end
    anyBusy = 1'b0;
    for (int r = 0; r < 32; r++) anyBusy |= nxtBusy[r];
    expDone = !rst && (mDrain || drain_req) && !anyBusy;

    checkOutput("model busy_vec", busy_vec, expVec);
    checkOutput("model issue_ready", 32'(issue_ready), 32'(expReady));
    checkOutput("model drain_done", 32'(drain_done), 32'(expDone));
    checkOutput("model stall_cnt", stall_cnt, mStall);

    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        mBusy[r]  = 1'b0;
        mOwner[r] = 0;
      end
      mDrain = 1'b0;
      mStall = '0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        mBusy[r]  = nxtBusy[r];
        mOwner[r] = nxtOwner[r];
      end
      mDrain = expDone ? 1'b0 : (mDrain || drain_req);
      if (issue_valid && !expReady && mStall != 32'hFFFF_FFFF) mStall = mStall + 32'd1;
    end
  end

  task automatic idleInputs();
    issue_valid   = 1'b0;
    issue_src0    = '0;
    issue_src1    = '0;
    issue_dst     = '0;
    issue_dst_wen = 1'b0;
    issue_fu      = '0;
    wb0_valid     = 1'b0;
    wb0_addr      = '0;
    wb0_fu        = '0;
    wb1_valid     = 1'b0;
    wb1_addr      = '0;
    wb1_fu        = '0;
    flush         = 1'b0;
    drain_req     = 1'b0;
  endtask

  task automatic issueReq(input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] d,
                          input logic wen, input logic [1:0] fu);
    issue_valid   = 1'b1;
    issue_src0    = s0;
    issue_src1    = s1;
    issue_dst     = d;
    issue_dst_wen = wen;
    issue_fu      = fu;
  endtask

  // Let the current inputs take effect at the next edge, then return to idle inputs.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    idleInputs();
  endtask

  initial begin
    rst = 1'b1;
    idleInputs();
    issue_valid = 1'b1;
    @(negedge clk);
    checkOutput("reset ready", 32'(issue_ready), 0);
    checkOutput("reset busy", busy_vec, 0);
    checkOutput("reset stall", stall_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idleInputs();

    issueReq(5'd0, 5'd0, 5'd5, 1'b1, 2'd1);
    @(negedge clk);
    checkOutput("issue r5 ready", 32'(issue_ready), 1);
    applyStimulus();

    issueReq(5'd5, 5'd0, 5'd0, 1'b0, 2'd0);
    @(negedge clk);
    checkOutput("r5 busy", busy_vec, 32'h0000_0020);
    checkOutput("raw r5 stall", 32'(issue_ready), 0);
    applyStimulus();

    issueReq(5'd5, 5'd0, 5'd0, 1'b0, 2'd0);
    wb0_valid = 1'b1; wb0_addr = 5'd5; wb0_fu = 2'd1;
    @(negedge clk);
    checkOutput("stall count one", stall_cnt, 1);
`ifdef SB_WB_BYPASS_EN
    checkOutput("raw wb cycle ready", 32'(issue_ready), 1);
`else
    checkOutput("raw wb cycle ready", 32'(issue_ready), 0);
`endif
    applyStimulus();

    issueReq(5'd5, 5'd0, 5'd0, 1'b0, 2'd0);
    @(negedge clk);
    checkOutput("r5 cleared", busy_vec, 0);
    checkOutput("after wb ready", 32'(issue_ready), 1);
`ifdef SB_WB_BYPASS_EN
    checkOutput("stall after wb", stall_cnt, 1);
`else
    checkOutput("stall after wb", stall_cnt, 2);
`endif
    applyStimulus();

    issueReq(5'd0, 5'd0, 5'd0, 1'b1, 2'd3);
    @(negedge clk);
    checkOutput("dst r0 ready", 32'(issue_ready), 1);
    applyStimulus();
    @(negedge clk);
    checkOutput("dst r0 ignored", busy_vec, 0);

    issueReq(5'd0, 5'd0, 5'd7, 1'b1, 2'd2);
    applyStimulus();
    wb0_valid = 1'b1; wb0_addr = 5'd7; wb0_fu = 2'd3;
    applyStimulus();
    @(negedge clk);
    checkOutput("stale wb ignored", busy_vec, 32'h0000_0080);
    wb1_valid = 1'b1; wb1_addr = 5'd7; wb1_fu = 2'd2;
    applyStimulus();
    @(negedge clk);
    checkOutput("owner wb clears", busy_vec, 0);

    issueReq(5'd0, 5'd0, 5'd8, 1'b1, 2'd1);
    applyStimulus();
    wb0_valid = 1'b1; wb0_addr = 5'd8; wb0_fu = 2'd3;
    wb1_valid = 1'b1; wb1_addr = 5'd8; wb1_fu = 2'd1;
    applyStimulus();
    @(negedge clk);
    checkOutput("dual wb one match", busy_vec, 0);

    issueReq(5'd0, 5'd0, 5'd9, 1'b1, 2'd0);
    applyStimulus();
    issueReq(5'd0, 5'd0, 5'd9, 1'b1, 2'd0);
    wb0_valid = 1'b1; wb0_addr = 5'd9; wb0_fu = 2'd0;
    @(negedge clk);
`ifdef SB_WB_BYPASS_EN
    checkOutput("waw wb cycle ready", 32'(issue_ready), 1);
`else
    checkOutput("waw wb cycle ready", 32'(issue_ready), 0);
`endif
    applyStimulus();
    @(negedge clk);
`ifdef SB_WB_BYPASS_EN
    checkOutput("issue wins over wb", busy_vec, 32'h0000_0200);
`else
    checkOutput("issue wins over wb", busy_vec, 0);
`endif
    wb0_valid = 1'b1; wb0_addr = 5'd9; wb0_fu = 2'd0;
    applyStimulus();
    @(negedge clk);
    checkOutput("r9 owner fu0 clears", busy_vec, 0);

    issueReq(5'd0, 5'd0, 5'd3, 1'b1, 2'd1);
    applyStimulus();
    issueReq(5'd0, 5'd0, 5'd4, 1'b1, 2'd2);
    applyStimulus();
    drain_req = 1'b1;
    issueReq(5'd0, 5'd0, 5'd0, 1'b0, 2'd0);
    @(negedge clk);
    checkOutput("drain req busy", busy_vec, 32'h0000_0018);
    checkOutput("drain req ready", 32'(issue_ready), 0);
    checkOutput("drain req done", 32'(drain_done), 0);
    applyStimulus();
    wb0_valid = 1'b1; wb0_addr = 5'd3; wb0_fu = 2'd1;
    @(negedge clk);
    checkOutput("drain r3 done", 32'(drain_done), 0);
    checkOutput("draining ready", 32'(issue_ready), 0);
    applyStimulus();
    wb1_valid = 1'b1; wb1_addr = 5'd4; wb1_fu = 2'd2;
    @(negedge clk);
    checkOutput("drain r4 done", 32'(drain_done), 1);
    applyStimulus();
    @(negedge clk);
    checkOutput("post drain done", 32'(drain_done), 0);
    checkOutput("post drain ready", 32'(issue_ready), 1);

    drain_req = 1'b1;
    @(negedge clk);
    checkOutput("empty drain done", 32'(drain_done), 1);
    checkOutput("empty drain ready", 32'(issue_ready), 0);
    applyStimulus();
    @(negedge clk);
    checkOutput("empty drain run", 32'(issue_ready), 1);

    for (int i = 0; i < 6; i++) begin
      issueReq(5'd0, 5'd0, 5'(10 + i), 1'b1, 2'(i % 4));
      applyStimulus();
    end
    issueReq(5'd0, 5'd0, 5'd20, 1'b1, 2'd1);
    flush = 1'b1;
    @(negedge clk);
    checkOutput("six busy", busy_vec, 32'h0000_FC00);
    checkOutput("flush rejects", 32'(issue_ready), 0);
    applyStimulus();
    @(negedge clk);
    checkOutput("flush empties", busy_vec, 0);

    issueReq(5'd0, 5'd0, 5'd21, 1'b1, 2'd3);
    applyStimulus();
    drain_req = 1'b1;
    @(negedge clk);
    checkOutput("drain r21 done", 32'(drain_done), 0);
    applyStimulus();
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush in drain done", 32'(drain_done), 1);
    applyStimulus();
    @(negedge clk);
    checkOutput("after flush drain", busy_vec, 0);
    checkOutput("after flush ready", 32'(issue_ready), 1);

    issueReq(5'd0, 5'd0, 5'd22, 1'b1, 2'd0);
    applyStimulus();
    drain_req = 1'b1;
    applyStimulus();
    rst = 1'b1;
    wb0_valid = 1'b1; wb0_addr = 5'd22; wb0_fu = 2'd0;
    @(negedge clk);
    checkOutput("reset mid drain done", 32'(drain_done), 0);
    checkOutput("reset mid ready", 32'(issue_ready), 0);
    applyStimulus();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset mid busy", busy_vec, 0);
    checkOutput("reset mid stall", stall_cnt, 0);
    checkOutput("reset mid run", 32'(issue_ready), 1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
